// File: rtl/fpu_cmp_arbiter.sv
// Round-robin arbiter that time-shares one sequential FPU sub-unit between
// N_REQ requesters. One transaction is in flight at a time. A watchdog forces
// completion if the unit never accepts or never answers.
module fpu_cmp_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ-1:0][4:0]  req_op,
  input  logic [N_REQ-1:0][31:0] req_a,
  input  logic [N_REQ-1:0][31:0] req_b,
  output logic [N_REQ-1:0]       rsp_valid,
  input  logic [N_REQ-1:0]       rsp_ready,
  output logic [31:0]            rsp_int,
  output logic                   rsp_IV,
  output logic                   rsp_TO,
  output logic                   unit_valid,
  input  logic                   unit_ready,
  output logic [4:0]             unit_op,
  output logic [31:0]            unit_a,
  output logic [31:0]            unit_b,
  input  logic                   unit_rvalid,
  output logic                   unit_rready,
  input  logic [31:0]            unit_int,
  input  logic                   unit_IV
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e         state_q, state_d;
  logic [IW-1:0]  g_q, g_d, ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [4:0]     op_q, op_d;
  logic [31:0]    a_q, a_d, b_q, b_d;
  logic [31:0]    rint_q, rint_d;
  logic           riv_q, riv_d, rto_q, rto_d;
  logic [IW-1:0]  gnext;
  logic           hit;
  logic           tmo;

  // (base + k) mod N_REQ without a divider; k is always < N_REQ
  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return IW'(s);
  endfunction

  // Round-robin pick: scan from the farthest offset down so the nearest
  // valid requester at or after ptr is the one left standing.
  always_comb begin
    gnext = ptr_q;
    hit   = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[rr_idx(ptr_q, k)]) begin
        gnext = rr_idx(ptr_q, k);
        hit   = 1'b1;
      end
    end
  end

  // Watchdog fires on the last allowed ISSUE/WAIT cycle; >= covers an ISSUE
  // handshake on that last cycle landing in WAIT with the budget already spent.
  assign tmo = (cnt_q >= CW'(TIMEOUT - 1));

  // Next-state and handshake outputs
  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rint_d      = rint_q;
    riv_d       = riv_q;
    rto_d       = rto_q;
    req_ready   = '0;
    rsp_valid   = '0;
    unit_valid  = 1'b0;
    unit_rready = 1'b0;
    case (state_q)
      IDLE: begin
        // reset_n gate keeps every output low while reset is held
        if (hit && reset_n) begin
          req_ready[gnext] = 1'b1;
          op_d    = req_op[gnext];
          a_d     = req_a[gnext];
          b_d     = req_b[gnext];
          g_d     = gnext;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        unit_valid = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        if (unit_ready) begin
          state_d = WAIT;
        end else if (tmo) begin
          rint_d  = '0;
          riv_d   = 1'b0;
          rto_d   = 1'b1;
          state_d = RESP;
        end
      end
      WAIT: begin
        unit_rready = 1'b1;
        cnt_d       = cnt_q + 1'b1;
        if (unit_rvalid) begin
          rint_d  = unit_int;
          riv_d   = unit_IV;
          rto_d   = 1'b0;
          state_d = RESP;
        end else if (tmo) begin
          rint_d  = '0;
          riv_d   = 1'b0;
          rto_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid[g_q] = 1'b1;
        if (rsp_ready[g_q]) begin
          ptr_d   = (g_q == IW'(N_REQ - 1)) ? '0 : g_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latch registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rint_q  <= '0;
      riv_q   <= 1'b0;
      rto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rint_q  <= rint_d;
      riv_q   <= riv_d;
      rto_q   <= rto_d;
    end
  end

  assign unit_op = op_q;
  assign unit_a  = a_q;
  assign unit_b  = b_q;
  assign rsp_int = (state_q == RESP) ? rint_q : '0;
  assign rsp_IV  = (state_q == RESP) & riv_q;
  assign rsp_TO  = (state_q == RESP) & rto_q;

endmodule
